lcd_bus_responder: RTL and testbench

- Behavioural/synthesizable model of the display end of our 8-bit HD44780-style LCD bus: the responder to the LCD write controller.
- Captures transactions on the falling edge of lcd_en, decodes commands and character writes, and holds a 2x16 DDRAM plus cursor and display state.
- Supports busy-flag/address reads and data reads.
- Used as the bench target for controller testing, and on-FPGA to mirror LCD contents to a debug or video path.

---
 rtl/lcd_bus_pkg.sv | 17 +
 rtl/lcd_bus_responder_ddram.sv | 20 ++
 rtl/lcd_bus_responder.sv | 157 +++++++++++++++
 tb/tb_lcd_bus_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: opcodes, FSM encoding and address-counter step shared by the LCD bus responder.
package lcd_bus_pkg;
  localparam logic [7:0] CLEAR_DISPLAY  = 8'h01;
  localparam logic [7:0] HOME           = 8'h02;
  localparam logic [7:0] ENTRY_MODE_SET = 8'h06;
  localparam logic [7:0] DISPLAY_ON     = 8'h0C;
  localparam logic [7:0] CURSOR_LEFT    = 8'h10;
  localparam logic [7:0] CURSOR_RIGHT   = 8'h14;
  localparam logic [7:0] SET_DDRAM      = 8'h80;
  localparam logic [1:0] ST_READY    = 2'd0;
  localparam logic [1:0] ST_EXEC     = 2'd1;
  localparam logic [1:0] ST_CLEARING = 2'd2;
  // natural 5-bit wrap gives 15->16, 31->0 and 0->31
  function automatic logic [4:0] ac_step(input logic [4:0] ac, input logic inc);
    return inc ? ac + 5'd1 : ac - 5'd1;
  endfunction
endpackage

// File: rtl/lcd_bus_responder_ddram.sv
// lcd_ddram: 32x8 display RAM, one write port, combinational bus read, registered mirror read.
module lcd_ddram (
  input  logic       clk,
  input  logic       reset,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] raddr_i,
  output logic [7:0] rdata_o,
  input  logic [4:0] maddr_i,
  output logic [7:0] mdata_o
);
  logic [7:0] mem_q [32];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
  always_ff @(posedge clk or posedge reset)
    if (reset) mdata_o <= '0;
    else mdata_o <= mem_q[maddr_i];
endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: display end of the 8-bit HD44780-style bus; decodes transactions
// on the falling edge of lcd_en and holds DDRAM, cursor and display state.
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter int         CMD_CYCLES = 4,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_data_in,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       busy,
  output logic [4:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic [3:0] disp_shift,
  input  logic [4:0] disp_addr,
  output logic [7:0] disp_char,
  output logic       protocol_err
);
  logic       en_q, rs_q, rw_q;
  logic [7:0] data_q;
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] clr_q, clr_d, ac_q, ac_d;
  logic [3:0] sh_q, sh_d;
  logic [2:0] dcb_q, dcb_d;
  logic       inc_q, inc_d, es_q, es_d, err_q, err_d;
  logic       fire, exec, we;
  logic [4:0] wa;
  logic [7:0] wd, ram_rd;
  assign fire = en_q & ~lcd_en;
  assign busy = state_q != ST_READY;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    ac_d    = ac_q;
    sh_d    = sh_q;
    dcb_d   = dcb_q;
    inc_d   = inc_q;
    es_d    = es_q;
    err_d   = err_q;
    exec    = 1'b0;
    we      = 1'b0;
    wa      = clr_q;
    wd      = BLANK_CHAR;
    if (state_q == ST_CLEARING) begin
      we    = 1'b1;
      clr_d = clr_q + 5'd1;
      if (clr_q == 5'd31) state_d = ST_READY;
    end else if (state_q == ST_EXEC) begin
      if (cnt_q == 8'd0) state_d = ST_READY;
      else cnt_d = cnt_q - 8'd1;
    end
    if (fire && busy && (rs_q || !rw_q)) err_d = 1'b1;
    if (fire && !busy) begin
      if (rs_q) begin
        we   = !rw_q;
        wa   = ac_q;
        wd   = data_q;
        ac_d = ac_step(ac_q, inc_q);
        exec = 1'b1;
      end else if (!rw_q) begin
        // the highest set bit selects the instruction
        if (data_q[7]) begin
          ac_d = {data_q[6], data_q[3:0]};
          exec = 1'b1;
        end else if (data_q[6] || data_q[5]) begin
          exec = 1'b1;
        end else if (data_q[4]) begin
          if (data_q[3]) sh_d = data_q[2] ? sh_q + 4'd1 : sh_q - 4'd1;
          else ac_d = ac_step(ac_q, data_q[2]);
          exec = 1'b1;
        end else if (data_q[3]) begin
          dcb_d = data_q[2:0];
          exec  = 1'b1;
        end else if (data_q[2]) begin
          inc_d = data_q[1];
          es_d  = data_q[0];
          exec  = 1'b1;
        end else if (data_q[1]) begin
          ac_d = '0;
          sh_d = '0;
          exec = 1'b1;
        end else if (data_q[0]) begin
          ac_d    = '0;
          sh_d    = '0;
          inc_d   = 1'b1;
          clr_d   = '0;
          state_d = ST_CLEARING;
        end
      end
    end
    if (exec) begin
      state_d = ST_EXEC;
      cnt_d   = 8'(CMD_CYCLES - 1);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      state_q <= ST_CLEARING;
      cnt_q   <= '0;
      clr_q   <= '0;
      ac_q    <= '0;
      sh_q    <= '0;
      dcb_q   <= '0;
      inc_q   <= 1'b1;
      es_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q    <= lcd_en;
      rs_q    <= lcd_rs;
      rw_q    <= lcd_rw;
      data_q  <= lcd_data_in;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      ac_q    <= ac_d;
      sh_q    <= sh_d;
      dcb_q   <= dcb_d;
      inc_q   <= inc_d;
      es_q    <= es_d;
      err_q   <= err_d;
    end
  lcd_ddram u_ddram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we),
    .waddr_i (wa),
    .wdata_i (wd),
    .raddr_i (ac_q),
    .rdata_o (ram_rd),
    .maddr_i ({disp_addr[4], disp_addr[3:0] + sh_q}),
    .mdata_o (disp_char)
  );
  assign lcd_data_oe  = lcd_en & lcd_rw;
  assign lcd_data_out = !lcd_data_oe ? 8'h00 : lcd_rs ? ram_rd : {busy, ac_q[4], 2'b00, ac_q[3:0]};
  assign cursor_addr  = ac_q;
  assign {display_on, cursor_on, blink_on} = dcb_q;
  assign entry_inc    = inc_q;
  assign entry_shift  = es_q;
  assign disp_shift   = sh_q;
  assign protocol_err = err_q;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: vector table plus scoreboard bench for the LCD bus responder.
module tb_lcd_bus_responder;
  import lcd_bus_pkg::*;
  logic       clk = 0, reset = 1, lcd_rs = 0, lcd_rw = 0, lcd_en = 0;
  logic [7:0] lcd_data_in = 0;
  logic [4:0] disp_addr = 0;
  logic [7:0] lcd_data_out, disp_char;
  logic       lcd_data_oe, busy, display_on, cursor_on, blink_on, entry_inc, entry_shift, protocol_err;
  logic [4:0] cursor_addr;
  logic [3:0] disp_shift;
  lcd_bus_responder #(.CMD_CYCLES(4), .BLANK_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset), .lcd_data_in(lcd_data_in), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe), .busy(busy),
    .cursor_addr(cursor_addr), .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .entry_shift(entry_shift), .disp_shift(disp_shift),
    .disp_addr(disp_addr), .disp_char(disp_char), .protocol_err(protocol_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic rs; logic [7:0] d; logic [4:0] ac;} vec_t;
  vec_t        vec[10];
  int          checks = 0, errors = 0;
  logic [7:0]  model[32];
  logic [3:0]  sh_m = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  rd;
  int          n;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pop_check(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0h", name, act);
    end else check(name, act, exp_q.pop_front());
  endtask
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, output logic [7:0] r);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1;
    #1 r = lcd_data_out;
    @(posedge clk); #1;
    lcd_en = 0; lcd_rw = 0;
  endtask
  task automatic wait_ready();
    int k = 0;
    repeat (2) @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("ready_timeout", busy, 0);
  endtask
  task automatic mirror(input logic [4:0] a);
    @(negedge clk);
    disp_addr = a;
    exp_q.push_back({24'h0, model[{a[4], a[3:0] + sh_m}]});
    @(negedge clk);
    pop_check($sformatf("mirror_%0d", a), disp_char);
  endtask
  task automatic count_clear();
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clear_busy_cycles", n, 32);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    vec[0] = '{1'b0, CLEAR_DISPLAY, 5'd0};
    vec[1] = '{1'b0, ENTRY_MODE_SET, 5'd0};
    vec[2] = '{1'b0, DISPLAY_ON, 5'd0};
    vec[3] = '{1'b1, 8'h57, 5'd1};
    vec[4] = '{1'b1, 8'h41, 5'd2};
    vec[5] = '{1'b1, 8'h53, 5'd3};
    vec[6] = '{1'b1, 8'h48, 5'd4};
    vec[7] = '{1'b1, 8'h49, 5'd5};
    vec[8] = '{1'b1, 8'h4E, 5'd6};
    vec[9] = '{1'b1, 8'h47, 5'd7};
    #12;
    check("rst_busy", busy, 1);
    check("rst_ac", cursor_addr, 0);
    check("rst_ctrl", {display_on, cursor_on, blink_on, entry_inc, entry_shift}, 5'b00010);
    check("rst_shift", disp_shift, 0);
    check("rst_err", protocol_err, 0);
    check("rst_char", disp_char, 0);
    check("rst_oe", {lcd_data_oe, lcd_data_out}, 0);
    @(negedge clk);
    reset = 0;
    count_clear();
    for (int i = 0; i < 32; i++) mirror(5'(i));
    xfer(0, 1, 8'h00, rd);
    check("status_idle", rd, 8'h00);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({27'h0, vec[i].ac});
      xfer(vec[i].rs, 0, vec[i].d, rd);
      if (vec[i].rs) model[vec[i].ac - 5'd1] = vec[i].d;
      wait_ready();
      pop_check($sformatf("vec%0d_ac", i), cursor_addr);
    end
    check("disp_on", display_on, 1);
    check("cursor_off", cursor_on, 0);
    for (int i = 0; i < 7; i++) mirror(5'(i));
    xfer(0, 0, SET_DDRAM, rd); wait_ready();
    xfer(1, 1, 8'h00, rd); wait_ready();
    check("data_read", rd, 8'h57);
    check("read_ac_step", cursor_addr, 1);
    xfer(0, 0, 8'hC5, rd); wait_ready();
    check("set_ddram_c5", cursor_addr, 21);
    xfer(1, 0, 8'h58, rd); model[21] = 8'h58; wait_ready();
    mirror(21);
    xfer(0, 1, 8'h00, rd);
    check("status_46", rd, 8'h46);
    xfer(0, 0, 8'h8F, rd); wait_ready();
    xfer(1, 0, 8'h41, rd); model[15] = 8'h41; wait_ready();
    xfer(1, 0, 8'h42, rd); model[16] = 8'h42; wait_ready();
    check("line_wrap_ac", cursor_addr, 17);
    mirror(15);
    mirror(16);
    xfer(0, 0, 8'h04, rd); wait_ready();
    check("entry_dec", entry_inc, 0);
    xfer(0, 0, SET_DDRAM, rd); wait_ready();
    xfer(1, 0, 8'h43, rd); model[0] = 8'h43; wait_ready();
    check("dec_wrap_ac", cursor_addr, 31);
    xfer(1, 0, 8'h44, rd); model[31] = 8'h44; wait_ready();
    check("dec_ac_30", cursor_addr, 30);
    mirror(0);
    mirror(31);
    check("err_clean", protocol_err, 0);
    xfer(1, 0, 8'h45, rd); model[30] = 8'h45;
    xfer(1, 0, 8'h46, rd);
    xfer(0, 1, 8'h00, rd);
    check("status_busy_bit", rd[7], 1);
    wait_ready();
    check("protocol_err", protocol_err, 1);
    check("ignored_ac", cursor_addr, 29);
    mirror(29);
    mirror(30);
    xfer(0, 0, 8'h1C, rd); sh_m = 1; wait_ready();
    check("shift_right", disp_shift, 1);
    mirror(0);
    mirror(15);
    xfer(1, 0, 8'h5A, rd);
    repeat (2) @(negedge clk);
    check("busy_mid_exec", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    sh_m = 0;
    count_clear();
    check("post_rst_shift", disp_shift, 0);
    check("post_rst_err", protocol_err, 0);
    check("post_rst_ac", cursor_addr, 0);
    check("post_rst_inc", entry_inc, 1);
    mirror(0);
    mirror(21);
    mirror(29);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
